data_sync_launcher: RTL
=======================

// Module: data_sync_launcher
// PURPOSE
//  Source-side launcher for the bus-enable/data CDC crossing. Buffers words from the
//  source clock domain in a small FIFO and presents each one on a held-stable data bus
//  while generating a timed bus_enable level. The destination-domain synchronizer
//  captures the word on the rising edge of that level. Sits in the source domain,
//  between the producer (UART RX / ALU / reg-file path) and the clock-domain boundary.
// PARAMETERS
//  BUS_WIDTH     8  width of data words
//  FIFO_DEPTH    4  words buffered; power of 2, >=2
//  HOLD_CYCLES   4  cycles bus_enable_out is held high; >=1; must cover >= NUM_OF_STAGES+1 dest clocks
//  GUARD_CYCLES  4  cycles bus_enable_out is held low after HOLD (data still stable); >=1; same rule
// PORTS
//  clk              in   1                  source-domain clock, rising edge
//  reset_n          in   1                  asynchronous active-low reset
//  data_in          in   BUS_WIDTH          word from producer
//  data_valid_in    in   1                  data_in valid
//  data_ready_out   out  1                  FIFO can accept; = !full
//  bus_enable_out   out  1                  registered enable level, to dest synchronizer
//  sync_data_out    out  BUS_WIDTH          registered data bus, to dest synchronizer
//  fifo_level_out   out  $clog2(FIFO_DEPTH)+1  words currently in FIFO
//  busy_out         out  1                  FSM not IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (async, immediate): FIFO empty, pointers 0, state IDLE, bus_enable_out=0,
//   sync_data_out=0, fifo_level_out=0, data_ready_out=1, busy_out=0. Reset mid-transfer
//   drops enable at once and discards the in-flight word and all buffered words.
//  FIFO: push on (data_valid_in && data_ready_out) at clk edge. Pointers wrap mod FIFO_DEPTH.
//   data_ready_out=0 when full; valid while full is ignored (producer holds word).
//   Push and pop on the same edge: level unchanged, both pointers advance.
//   No bypass: a word pushed into an empty FIFO is poppable on the next cycle.
//  FSM states:
//   IDLE   : if FIFO non-empty -> pop, load sync_data_out, go SETUP; else stay.
//   SETUP  : 1 cycle, enable low, data stable -> ASSERT.
//   ASSERT : bus_enable_out=1 for exactly HOLD_CYCLES cycles -> GUARD.
//   GUARD  : bus_enable_out=0 for exactly GUARD_CYCLES cycles -> IDLE.
//  sync_data_out changes only on the IDLE pop; it is stable from SETUP through the end
//   of GUARD and holds its last value while IDLE.
//  Latency: word accepted at edge N -> sync_data_out valid after edge N+1, enable rises
//   at edge N+2. Back-to-back period = HOLD_CYCLES+GUARD_CYCLES+2 cycles per word.
//  One down-counter, width $clog2(max(HOLD_CYCLES,GUARD_CYCLES))+1, loaded on state entry.
//  Words leave in push order; no word is dropped or duplicated except by reset.
// TESTING
//  1 Single word 8'hA5 pushed at edge 0 -> sync_data_out=A5 after edge 1; enable high
//    edges 2..6 (4 cycles); busy_out low again after edge 10.
//  2 Push 4 words 01..04 back-to-back -> ready low once level=4 (minus pops); enable rises
//    at edges 2,12,22,32 with data 01,02,03,04 in order.
//  3 Hold valid while full -> no push, level stays at 4; the word is accepted on the
//    first cycle ready returns high, and the level does not exceed 4.
//  4 Push on the same edge as an IDLE pop with level=2 -> level stays 2, order preserved.
//  5 Assert reset_n low during ASSERT -> enable=0 and level=0 immediately; after release
//    no stale word is emitted.
//  6 Stream 3*FIFO_DEPTH random words with random valid gaps -> scoreboard order exact,
//    pointer wrap exercised, data stable whenever enable is high.

Source files
------------

// File: rtl/data_sync_launcher.sv
// Source-side launcher for the bus-enable/data CDC crossing: a small FIFO feeding a
// held-stable data bus plus a timed enable level for the destination synchronizer.
module data_sync_launcher #(
  parameter int BUS_WIDTH    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int HOLD_CYCLES  = 4,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [BUS_WIDTH-1:0]          data_in,
  input  logic                          data_valid_in,
  output logic                          data_ready_out,
  output logic                          bus_enable_out,
  output logic [BUS_WIDTH-1:0]          sync_data_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
  output logic                          busy_out
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int MAX_CNT = (HOLD_CYCLES > GUARD_CYCLES) ? HOLD_CYCLES : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ASSERT,
    S_GUARD
  } state_t;

  state_t               state, state_nxt;
  logic [BUS_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level;
  logic [CNT_W-1:0]     cnt;
  logic                 full, empty, push, pop;
  logic                 load_hold, load_guard;

  assign full           = (level == DEPTH_L);
  assign empty          = (level == '0);
  assign push           = data_valid_in && !full;
  assign data_ready_out = !full;
  assign fifo_level_out = level;
  assign busy_out       = (state != S_IDLE) || !empty;

  // FIFO storage stage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Launch control stage
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    load_hold  = 1'b0;
    load_guard = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        load_hold = 1'b1;
        state_nxt = S_ASSERT;
      end
      S_ASSERT: begin
        if (cnt == '0) begin
          load_guard = 1'b1;
          state_nxt  = S_GUARD;
        end
      end
      S_GUARD: begin
        if (cnt == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load_hold)       cnt <= HOLD_LD;
      else if (load_guard) cnt <= GUARD_LD;
      else if (cnt != '0)  cnt <= cnt - CNT_W'(1);
    end
  end

  // Output register stage: enable and data leave straight from flops toward the crossing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_enable_out <= 1'b0;
      sync_data_out  <= '0;
    end else begin
      bus_enable_out <= (state_nxt == S_ASSERT);
      if (pop) sync_data_out <= mem[rd_ptr];
    end
  end

endmodule
